// File: rtl/dbg_print_pkg.sv
// Shared FSM state type and default parameters for the debug print port.
// Used by dbg_print_fifo and dbg_print_port (optional macro DBG_PRINT_CHECKSUM_EN).
package dbg_print_pkg;

    localparam int         DBG_DATA_W_DEF     = 8;
    localparam int         DBG_DEPTH_DEF      = 16;
    localparam int         DBG_STB_CYCLES_DEF = 4;
    localparam int         DBG_GAP_CYCLES_DEF = 2;
    localparam logic [7:0] DBG_EOT_CHAR_DEF   = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } dbg_state_e;

endpackage

// File: rtl/dbg_print_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; DEPTH must be a power of two.
// Pushes into a full FIFO and pops from an empty one are ignored.
module dbg_print_fifo
    import dbg_print_pkg::*;
#(
    parameter int DATA_W = DBG_DATA_W_DEF,
    parameter int DEPTH  = DBG_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W:0]    level_q;
    logic              doPush;
    logic              doPop;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign doPush  = push_i && !full_o && !clr_i;
    assign doPop   = pop_i && !empty_o && !clr_i;
    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else if (clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + (PTR_W+1)'(1);
                2'b01:   level_q <= level_q - (PTR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dbg_print_port.sv
// Debug character print port: FIFO-buffered characters are strobed out to pads with setup/strobe/gap timing.
// Define DBG_PRINT_CHECKSUM_EN to build the running checksum on chk_o; otherwise chk_o is tied to zero.
module dbg_print_port
    import dbg_print_pkg::*;
#(
    parameter int                DATA_W     = DBG_DATA_W_DEF,
    parameter int                DEPTH      = DBG_DEPTH_DEF,
    parameter int                STB_CYCLES = DBG_STB_CYCLES_DEF,
    parameter int                GAP_CYCLES = DBG_GAP_CYCLES_DEF,
    parameter logic [DATA_W-1:0] EOT_CHAR   = DATA_W'(DBG_EOT_CHAR_DEF)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush_i,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_stb,
    output logic                   eot_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [DATA_W-1:0]      chk_o
);

    localparam int CNT_MAX = (STB_CYCLES > GAP_CYCLES) ? STB_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    dbg_state_e        state_q;
    logic [DATA_W-1:0] data_q;
    logic              stb_q;
    logic              eot_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              fifoFull;
    logic              fifoEmpty;
    logic [DATA_W-1:0] fifoHead;
    logic              pushEn;
    logic              popEn;
    logic              strobeDone;

    // Ready is also held low during reset so nothing is accepted while the block is held.
    assign in_ready   = !fifoFull && !flush_i && !eot_q && !wb_rst_i;
    assign pushEn     = in_valid && in_ready;
    assign popEn      = (state_q == ST_IDLE) && !fifoEmpty && !eot_q && !flush_i;
    assign strobeDone = (state_q == ST_STROBE) && (cnt_q == STB_LAST);

    dbg_print_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr_i   (flush_i),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .wdata_i (in_data),
        .rdata_o (fifoHead),
        .level_o (level_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Flush leaves out_data untouched so the pads keep showing the last character.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            stb_q   <= 1'b0;
            eot_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            stb_q   <= 1'b0;
            eot_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (popEn) begin
                        data_q  <= fifoHead;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    stb_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (strobeDone) begin
                        stb_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                        if (data_q == EOT_CHAR) begin
                            eot_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data = data_q;
    assign out_stb  = stb_q;
    assign eot_o    = eot_q;

`ifdef DBG_PRINT_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q;
    logic [DATA_W-1:0] chk_d;

    // Only characters that finish their full strobe contribute to the sum.
    assign chk_d = chk_q + data_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            chk_q <= '0;
        end else if (flush_i) begin
            chk_q <= '0;
        end else if (strobeDone) begin
            chk_q <= chk_d;
        end
    end

    assign chk_o = chk_q;
`else
    assign chk_o = '0;
`endif

endmodule

// File: doc/dbg_print_port.md
DBG_PRINT_PORT -- requirements
Module: dbg_print_port

Interface
REQ-001 Parameter DATA_W, default 8, character width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, ≥2.
REQ-003 Parameter STB_CYCLES, default 4, out_stb high time in clocks, ≥1.
REQ-004 Parameter GAP_CYCLES, default 2, minimum low time between strobes, ≥1.
REQ-005 Parameter EOT_CHAR, default 8'h04, end-of-test character.
REQ-006 wb_clk_i  input  1  sole clock, rising edge.
REQ-007 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  character offered.
REQ-009 in_ready  output  1  character accepted when in_valid && in_ready at the clock edge.
REQ-010 in_data  input  DATA_W  character.
REQ-011 flush_i  input  1  synchronous clear of FIFO, FSM, eot_o and checksum.
REQ-012 out_data  output  DATA_W  character driven to pads.
REQ-013 out_stb  output  1  pad strobe; out_data valid while high.
REQ-014 eot_o  output  1  sticky: EOT_CHAR has been emitted.
REQ-015 level_o  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 chk_o  output  DATA_W  running checksum (DBG_PRINT_CHECKSUM_EN only; else tied 0).

Function
REQ-017 Registered FIFO of DEPTH entries; in_ready = !full && !flush_i && !eot_o.
REQ-018 Full FIFO: in_ready low even when a pop occurs that cycle; no overwrite.
REQ-019 Pointers wrap modulo DEPTH; level_o counts 0..DEPTH exactly.
REQ-020 FSM states IDLE, SETUP, STROBE, GAP.
REQ-021 IDLE: if FIFO non-empty and !eot_o, pop head into out_data register, go SETUP.
REQ-022 SETUP: one cycle, out_stb low, out_data stable; go STROBE.
REQ-023 STROBE: out_stb high exactly STB_CYCLES clocks, out_data unchanged; go GAP.
REQ-024 GAP: out_stb low GAP_CYCLES clocks; go IDLE.
REQ-025 Latency: character accepted at edge k into empty FIFO with FSM IDLE -> out_stb rises after edge k+2.
REQ-026 Back-to-back: strobe period = 1+STB_CYCLES+GAP_CYCLES+1 clocks while FIFO non-empty.
REQ-027 At STROBE->GAP transition, if out_data == EOT_CHAR, eot_o sets; no further pops until flush.
REQ-028 Simultaneous push and pop in non-full FIFO: both happen, level_o unchanged.
REQ-029 flush_i has priority over push, pop and FSM: next cycle FIFO empty, FSM IDLE, out_stb 0, eot_o 0, chk_o 0; out_data retains last value.
REQ-030 flush_i mid-STROBE truncates the strobe; eot_o not set by the truncated character.

Reset
REQ-031 wb_rst_i asserted: immediately out_stb=0, out_data=0, eot_o=0, level_o=0, chk_o=0, FSM IDLE, in_ready=0 while asserted.
REQ-032 Reset mid-strobe drops out_stb asynchronously; first post-reset strobe requires a new push.

Configuration
REQ-033 Macro DBG_PRINT_CHECKSUM_EN defined: chk_o = sum modulo 2^DATA_W of every character completing STROBE, updated the cycle after STROBE ends.
REQ-034 Macro undefined: chk_o constant 0, no adder or register synthesised.

Structure
REQ-035 Shared package dbg_print_pkg holds FSM state enum and default parameter constants.
REQ-036 Sub-module dbg_print_fifo (parametrised DATA_W/DEPTH sync FIFO with level) instantiated once.

Verification
REQ-037 Push 'H','i' (0x48,0x69) at defaults -> two strobes of 4 clocks, rising edges 8 clocks apart, out_data 0x48 then 0x69.
REQ-038 Push 17 characters at DEPTH=16 with FSM stalled in first strobe -> in_ready low at level_o=16, 17th accepted only after a pop, none lost.
REQ-039 Push 0x41,0x04,0x42 -> strobes 0x41,0x04 only; eot_o high after 0x04 strobe; level_o stays 1; flush_i -> level_o 0, eot_o 0.
REQ-040 Assert wb_rst_i during second STROBE cycle -> out_stb 0 same cycle, level_o 0; release, push 0x55 -> single strobe with 0x55.
REQ-041 With DBG_PRINT_CHECKSUM_EN, emit 0xF0,0x20 -> chk_o 0xF0 then 0x10 (wrap); without macro chk_o 0 throughout.
REQ-042 flush_i and in_valid in same cycle with level_o=3 -> push dropped, level_o 0 next cycle, out_stb 0.
